fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of `controlpath`. It owns the program counter and issues in-order requests to instruction memory over a valid/ready handshake. Returned words go into a prefetch FIFO; the FIFO head drives `Instr`, `PC` and `PCPlus4` to the decode/control stage. A taken branch (`PCSrc` with `PCTarget`) flushes the FIFO, drops in-flight responses and refetches from the target.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `FQ_DEPTH`, 4, prefetch FIFO entries; power of 2, ≥2; also caps outstanding requests

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; one clock, sampled on `clk` rising edge
- `PCSrc`  in  1  redirect request (Branch & Zero from `controlpath`)
- `PCTarget`  in  32  redirect address, valid when `PCSrc`=1
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_addr`  out  32  fetch address, word aligned
- `imem_resp_valid`  in  1  response valid; responses return in request order, no backpressure
- `imem_resp_data`  in  32  fetched instruction word
- `Instr`  out  32  FIFO head instruction
- `PC`  out  32  address of `Instr`
- `PCPlus4`  out  32  `PC`+4
- `instr_valid`  out  1  FIFO head valid
- `instr_ready`  in  1  consumer takes head
- `misalign`  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- Registers:
  - `fpc`: next fetch address.
  - `dpc`: PC of the FIFO head.
  - `outst`: in-flight request count, width clog2(FQ_DEPTH)+1.
  - `discard`: responses still to drop.
  - FIFO: count and read/write pointers.
- Request issue:
  - `imem_req_valid` = !reset && !PCSrc && (outst + count < FQ_DEPTH).
  - `imem_addr` = `fpc`.
  - Request fires when `imem_req_valid` & `imem_req_ready`. On fire: `fpc` += 4 and `outst` += 1.
  - Once asserted, valid and addr hold until accepted, except that a redirect withdraws them.
- Response handling:
  - Every `imem_resp_valid` decrements `outst`.
  - If `discard`>0, the word is dropped and `discard` decrements.
  - Otherwise the word is pushed to the FIFO. The entry is visible the following cycle; there is no bypass.
- Pop: fires on `instr_valid` & `instr_ready`; `dpc` += 4.
- Outputs:
  - `PC` = `dpc`; `PCPlus4` = `dpc`+4.
  - `Instr` = head word when `instr_valid`, else 32'h0000_0013 (NOP).
- Redirect (`PCSrc`=1 in cycle t):
  - No request issues in cycle t.
  - A pop handshake in cycle t completes normally.
  - A response arriving in cycle t is dropped.
  - At the t edge: FIFO emptied, `fpc`=`dpc`=`PCTarget` (bits [1:0] forced to 0), `discard` = `outst` − `imem_resp_valid`, `outst` updated likewise.
  - Back-to-back redirects: the last one wins; the `discard` arithmetic is unchanged.
- Arithmetic: all PC math is modulo 2^32, so 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset:
  - Reset values: `imem_req_valid`=0, `instr_valid`=0, `PC`=`RESET_PC`, `PCPlus4`=`RESET_PC`+4, `Instr`=32'h0000_0013, `misalign`=0.
  - `outst`, `discard` and FIFO are cleared.
  - Reset mid-operation drops all in-flight responses, including ones returning after reset. The memory is reset on the same `reset`.
- First request: `imem_req_valid`=1 in the first cycle after `reset` deasserts, with `imem_addr`=`RESET_PC`.
- Latency: request accepted in cycle t, response in cycle t+L → `instr_valid` in cycle t+L+1.
- Full FIFO: requests stall once outst+count=FQ_DEPTH. No response is ever lost.
- Simultaneous push and pop on a full FIFO is impossible by the request cap. When the FIFO is empty, a push and an attempted pop in the same cycle do not pop.
- Redirect: the first request to the target issues at cycle t+1. First target `instr_valid` is no earlier than t+L+2.
- Throughput: with L=1 and `imem_req_ready`=1, one instruction per cycle sustained.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `PCTarget`[1:0]≠0 sets `misalign`=1 from cycle t+1 onward.
  - It flushes as a normal redirect and then holds `imem_req_valid`=0 until `reset`.
  - `PC` shows the raw `PCTarget`.
- `FETCH_MISALIGN_TRAP_EN` undefined:
  - `misalign` is tied 0.
  - `PCTarget`[1:0] is ignored (forced 00) and fetch continues.

## Test plan
- Reset release, `RESET_PC`=32'h100, L=1, ready=1 → `imem_addr` 100,104,108…; `instr_valid` from cycle 3; `PC` increments by 4 per cycle with `instr_ready`=1.
- Hold `instr_ready`=0 with FQ_DEPTH=4 → exactly 4 requests issue, `imem_req_valid` drops, and the FIFO holds 4 words. Releasing ready drains them in order, with `PC`=100..10C.
- Memory latency L=3 with 2 in flight, then `PCSrc`=1, `PCTarget`=32'h200 → both stale responses dropped (`discard` 2→0); the next `Instr` comes from 200 and `PC`=200.
- `imem_req_ready`=0 for 5 cycles → `imem_addr` stable and `imem_req_valid` held. A redirect during the stall changes `imem_addr` to the target at t+1.
- `fpc` at 32'hFFFF_FFF8 → fetches FFFF_FFF8, FFFF_FFFC, 0000_0000; `PCPlus4` at FFFF_FFFC reads 0.
- With `FETCH_MISALIGN_TRAP_EN`, redirect to 32'h202 → `misalign`=1 at t+1 and no further requests; `reset` clears it and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues in-order imem requests and buffers returned words in a prefetch FIFO.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned redirect sets a sticky trap flag and halts fetch until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        misalign
);
    localparam int          AW      = $clog2(FQ_DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FQ_DEPTH);
    localparam logic [31:0] NOP_C   = 32'h0000_0013;

    logic [31:0]   fpc_r;
    logic [31:0]   dpc_r;
    logic [CW-1:0] outst_r;
    logic [CW-1:0] discard_r;
    logic [CW-1:0] count_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [31:0]   fifo_r [FQ_DEPTH];

    logic [CW:0]   occ_s;
    logic          req_valid_s;
    logic          req_fire_s;
    logic          push_s;
    logic          pop_s;
    logic          head_valid_s;
    logic          halt_s;
    logic [31:0]   tgt_fetch_s;
    logic [31:0]   tgt_pc_s;

    assign tgt_fetch_s = PCTarget & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_r;

    // Sticky trap flag: any redirect to a non-word address latches it until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_r <= 1'b0;
        end else if (PCSrc && (PCTarget[1:0] != 2'b00)) begin
            misalign_r <= 1'b1;
        end
    end

    assign halt_s   = misalign_r;
    assign tgt_pc_s = PCTarget;
    assign misalign = misalign_r;
`else
    assign halt_s   = 1'b0;
    assign tgt_pc_s = tgt_fetch_s;
    assign misalign = 1'b0;
`endif

    // Handshake qualifiers and FIFO head presentation.
    always_comb begin
        occ_s        = {1'b0, outst_r} + {1'b0, count_r};
        req_valid_s  = !reset && !PCSrc && !halt_s && (occ_s < DEPTH_C);
        req_fire_s   = req_valid_s && imem_req_ready;
        head_valid_s = (count_r != {CW{1'b0}});
        pop_s        = head_valid_s && instr_ready;
        // A response in a redirect cycle belongs to the old stream and is dropped.
        push_s       = imem_resp_valid && !PCSrc && (discard_r == {CW{1'b0}});
        Instr        = NOP_C;
        if (head_valid_s) begin
            Instr = fifo_r[rd_ptr_r];
        end else begin
            Instr = NOP_C;
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_addr      = fpc_r;
    assign instr_valid    = head_valid_s;
    assign PC             = dpc_r;
    assign PCPlus4        = dpc_r + 32'd4;

    // PC, in-flight accounting and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_r     <= RESET_PC;
            dpc_r     <= RESET_PC;
            outst_r   <= {CW{1'b0}};
            discard_r <= {CW{1'b0}};
            count_r   <= {CW{1'b0}};
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
        end else if (PCSrc) begin
            // Everything still in flight after this cycle is stale.
            fpc_r     <= tgt_fetch_s;
            dpc_r     <= tgt_pc_s;
            outst_r   <= outst_r - CW'(imem_resp_valid);
            discard_r <= outst_r - CW'(imem_resp_valid);
            count_r   <= {CW{1'b0}};
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
        end else begin
            if (req_fire_s) begin
                fpc_r <= fpc_r + 32'd4;
            end
            outst_r <= outst_r + CW'(req_fire_s) - CW'(imem_resp_valid);
            if (imem_resp_valid && (discard_r != {CW{1'b0}})) begin
                discard_r <= discard_r - CW'(1'b1);
            end
            if (pop_s) begin
                dpc_r    <= dpc_r + 32'd4;
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // FIFO storage; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_r[wr_ptr_r] <= imem_resp_data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with variable latency, expected-instruction scoreboard.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, PCSrc, imem_req_valid, imem_req_ready, imem_resp_valid;
    logic        instr_valid, instr_ready, misalign;
    logic [31:0] PCTarget, imem_addr, imem_resp_data, Instr, PC, PCPlus4;

    fetch_unit #(.RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pops   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard of instructions the consumer should see, in order.
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_ins_q[$];
    // Memory model: pending responses with due cycle.
    int          due_q[$];
    logic [31:0] dat_q[$];
    int          last_due = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    // Reference fetch stream.
    logic [31:0] fetch_pc  = RST_PC;
    int          req_count = 0;
    bit          stall_prev = 1'b0;
    logic [31:0] stall_addr = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_valid(input string nm, input int limit);
        bit got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            probe();
            if (instr_valid) got = 1'b1;
            else tick();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s actual=timeout expected=instr_valid within %0d cycles", nm, limit);
        end
    endtask

    // Memory: answers in order, one response per cycle at most, cleared by reset.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                due_q.delete();
                dat_q.delete();
                last_due        = 0;
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom;
            end else if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                imem_resp_valid = 1'b1;
                imem_resp_data  = dat_q.pop_front();
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom;
            end
        end
    end

    // Request tracker: checks the fetch stream and pushes expected instructions.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                check32("req_valid_in_reset", {31'd0, imem_req_valid}, 32'd0);
                exp_pc_q.delete();
                exp_ins_q.delete();
                fetch_pc   = RST_PC;
                req_count  = 0;
                stall_prev = 1'b0;
            end else begin
                if (PCSrc) check32("req_valid_in_redirect", {31'd0, imem_req_valid}, 32'd0);
                if (stall_prev && !PCSrc) begin
                    check32("stall_valid_hold", {31'd0, imem_req_valid}, 32'd1);
                    check32("stall_addr_hold", imem_addr, stall_addr);
                end
                if (imem_req_valid && imem_req_ready) begin
                    int due;
                    check32("req_addr", imem_addr, fetch_pc);
                    checks++;
                    if (exp_pc_q.size() >= DEPTH) begin
                        errors++;
                        $display("FAIL req_cap actual=%0d expected=<%0d", exp_pc_q.size(), DEPTH);
                    end
                    exp_pc_q.push_back(fetch_pc);
                    exp_ins_q.push_back(mem_word(fetch_pc));
                    due = cyc + int'($urandom_range(lat_min, lat_max));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    due_q.push_back(due);
                    dat_q.push_back(mem_word(imem_addr));
                    req_count++;
                    fetch_pc = fetch_pc + 32'd4;
                end
                stall_prev = imem_req_valid && !imem_req_ready && !PCSrc;
                stall_addr = imem_addr;
                if (PCSrc) begin
                    exp_pc_q.delete();
                    exp_ins_q.delete();
                    fetch_pc = PCTarget & 32'hFFFF_FFFC;
                end
            end
        end
    end

    // Monitor: compares every consumed instruction against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (instr_valid) begin
                if (instr_ready) begin
                    if (exp_pc_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_unexpected actual=PC %h expected=no instruction", PC);
                    end else begin
                        logic [31:0] epc;
                        logic [31:0] eins;
                        epc  = exp_pc_q.pop_front();
                        eins = exp_ins_q.pop_front();
                        check32("pop_pc", PC, epc);
                        check32("pop_instr", Instr, eins);
                        check32("pop_pcplus4", PCPlus4, epc + 32'd4);
`ifndef FETCH_MISALIGN_TRAP_EN
                        check32("misalign_tied", {31'd0, misalign}, 32'd0);
`endif
                        pops++;
                    end
                end
            end else begin
                check32("instr_nop", Instr, NOP);
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        reset = 1'b1; PCSrc = 1'b0; PCTarget = 32'd0;
        imem_req_ready = 1'b1; instr_ready = 1'b1;
        tick(); tick();
        probe();
        check32("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check32("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check32("rst_pc", PC, RST_PC);
        check32("rst_pcplus4", PCPlus4, RST_PC + 32'd4);
        check32("rst_instr", Instr, NOP);
        check32("rst_misalign", {31'd0, misalign}, 32'd0);

        // Reset release, L=1: first request immediately, first instruction two cycles later.
        tick(); reset = 1'b0;
        probe();
        check32("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check32("first_req_addr", imem_addr, RST_PC);
        tick(); probe();
        check32("first_latency_c1", {31'd0, instr_valid}, 32'd0);
        tick(); probe();
        check32("first_latency_c2", {31'd0, instr_valid}, 32'd1);
        check32("first_pc", PC, RST_PC);
        for (int i = 0; i < 10; i++) begin
            tick(); probe();
            check32("throughput_valid", {31'd0, instr_valid}, 32'd1);
        end

        // Consumer stalled: exactly DEPTH requests, then drain in order.
        tick(); reset = 1'b1; instr_ready = 1'b0;
        tick(); reset = 1'b0;
        run(10);
        probe();
        check32("full_req_count", 32'(req_count), 32'(DEPTH));
        check32("full_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check32("full_instr_valid", {31'd0, instr_valid}, 32'd1);
        check32("full_head_pc", PC, RST_PC);
        tick(); instr_ready = 1'b1;
        run(10);

        // L=3, two in flight, redirect to 0x200.
        reset = 1'b1; lat_min = 3; lat_max = 3;
        tick(); reset = 1'b0;
        tick(); tick();
        PCSrc = 1'b1; PCTarget = 32'h0000_0200;
        tick(); PCSrc = 1'b0;
        probe();
        check32("redir_addr", imem_addr, 32'h0000_0200);
        tick();
        wait_valid("redir_wait", 12);
        check32("redir_pc", PC, 32'h0000_0200);
        check32("redir_instr", Instr, mem_word(32'h0000_0200));
        tick(); run(6);

        // Memory stall, then redirect during the stall.
        lat_min = 1; lat_max = 1; imem_req_ready = 1'b0;
        run(5);
        probe();
        check32("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
        tick(); PCSrc = 1'b1; PCTarget = 32'h0000_0300;
        tick(); PCSrc = 1'b0;
        probe();
        check32("stall_redir_valid", {31'd0, imem_req_valid}, 32'd1);
        check32("stall_redir_addr", imem_addr, 32'h0000_0300);
        tick(); imem_req_ready = 1'b1;
        run(8);

        // Address wrap at the top of the address space.
        PCSrc = 1'b1; PCTarget = 32'hFFFF_FFF8;
        tick(); PCSrc = 1'b0;
        wait_valid("wrap_wait", 8);
        check32("wrap_pc0", PC, 32'hFFFF_FFF8);
        tick(); probe();
        check32("wrap_pc1", PC, 32'hFFFF_FFFC);
        check32("wrap_pcplus4", PCPlus4, 32'h0000_0000);
        tick(); probe();
        check32("wrap_pc2", PC, 32'h0000_0000);
        tick(); run(5);

        // Randomized traffic.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 3) != 0);
            PCSrc          = ($urandom_range(0, 19) == 0);
            PCTarget       = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            PCTarget       = PCTarget & 32'hFFFF_FFFC;
`endif
            reset          = !PCSrc && ($urandom_range(0, 499) == 0);
            tick();
        end
        PCSrc = 1'b0; reset = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
        run(20);
        checks++;
        if (pops <= 300) begin
            errors++;
            $display("FAIL liveness actual=%0d pops expected=>300", pops);
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        PCSrc = 1'b1; PCTarget = 32'h0000_0202;
        tick(); PCSrc = 1'b0;
        probe();
        check32("trap_misalign", {31'd0, misalign}, 32'd1);
        check32("trap_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check32("trap_pc", PC, 32'h0000_0202);
        tick(); run(4); probe();
        check32("trap_hold_valid", {31'd0, imem_req_valid}, 32'd0);
        check32("trap_hold_flag", {31'd0, misalign}, 32'd1);
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        probe();
        check32("trap_clear", {31'd0, misalign}, 32'd0);
        check32("trap_restart_valid", {31'd0, imem_req_valid}, 32'd1);
        check32("trap_restart_addr", imem_addr, RST_PC);
        tick(); run(5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
